// File: rtl/nes_i2c_pkg.sv
// nes_i2c_pkg: shared state encoding and constants for the I2C EEPROM target
package nes_i2c_pkg;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h50;
  localparam int BCW = 4;
  typedef enum logic [3:0] {
    IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO, WRDATA, ACK_WR, RDDATA, RDACK
  } state_e;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: synchronises raw SCL/SDA and detects SCL edges, START and STOP
module i2c_bus_sync (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  // [0],[1] are the two sync stages, [2] is the history stage
  always_comb begin
    scl_d = {scl_q[1:0], scl_in};
    sda_d = {sda_q[1:0], sda_in};
  end
  // an idle bus is high, so reset high to avoid spurious edges after reset
  always_ff @(posedge clk_in or negedge nrst_in)
    if (!nrst_in) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
    end
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start    = scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
  assign stop     = scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
endmodule

// File: rtl/i2c_eeprom_target.sv
// i2c_eeprom_target: 24-series style EEPROM I2C target driving an external sync RAM port
module i2c_eeprom_target
  import nes_i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEF_DEV_ADDR,
  parameter int         MEM_AW   = 15
) (
  input  logic              clk_in,
  input  logic              nrst_in,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe_out,
  output logic [MEM_AW-1:0] mem_a_out,
  input  logic [7:0]        mem_d_in,
  output logic              mem_rd_out,
  output logic [7:0]        mem_d_out,
  output logic              mem_wr_out,
  output logic              busy_out
);
  logic sda_s, scl_rise, scl_fall, start, stop;
  state_e state_q, state_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, hi_q, hi_d, mem_d_q, mem_d_d, byte_in;
  logic [MEM_AW-1:0] ptr_q, ptr_d, mem_a_q, mem_a_d;
  logic rd_q, rd_d, rd_pend_q, rd_pend_d, oe_q, oe_d, busy_q, busy_d;
  logic mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
  logic [15:0] addr16;
  i2c_bus_sync u_sync (
    .clk_in   (clk_in),
    .nrst_in  (nrst_in),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );
  assign byte_in = {shift_q[6:0], sda_s};
  assign addr16  = {hi_q, byte_in};
  // protocol FSM: receive bytes on SCL rise, drive ACK/read bits on SCL fall
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = rd_pend_q ? mem_d_in : shift_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    rd_d      = rd_q;
    rd_pend_d = mem_rd_q;
    oe_d      = oe_q;
    busy_d    = busy_q;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    mem_a_d   = mem_a_q;
    mem_d_d   = mem_d_q;
    if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start) begin
      state_d = DEVADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        DEVADDR, ADDR_HI, ADDR_LO, WRDATA: if (scl_rise) begin
          shift_d = byte_in;
          cnt_d   = cnt_q + BCW'(1);
          if (cnt_q == BCW'(7)) begin
            cnt_d = '0;
            if (state_q == DEVADDR) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                busy_d   = 1'b1;
                rd_d     = byte_in[0];
                mem_rd_d = byte_in[0];
                if (byte_in[0]) mem_a_d = ptr_q;
                state_d  = ACK_DEV;
              end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
              end
            end else if (state_q == ADDR_HI) begin
              hi_d    = byte_in;
              state_d = ACK_HI;
            end else if (state_q == ADDR_LO) begin
              ptr_d   = addr16[MEM_AW-1:0];
              state_d = ACK_LO;
            end else begin
              mem_wr_d = 1'b1;
              mem_a_d  = ptr_q;
              mem_d_d  = byte_in;
              ptr_d    = ptr_q + MEM_AW'(1);
              state_d  = ACK_WR;
            end
          end
        end
        ACK_DEV, ACK_HI, ACK_LO, ACK_WR: if (scl_fall) begin
          oe_d = ~oe_q;
          if (oe_q) begin
            state_d = state_q == ACK_HI ? ADDR_LO :
                      state_q != ACK_DEV ? WRDATA :
                      rd_q ? RDDATA : ADDR_HI;
            if (state_q == ACK_DEV && rd_q) begin
              oe_d    = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = BCW'(1);
            end
          end
        end
        RDDATA: if (scl_fall) begin
          if (cnt_q == BCW'(8)) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = RDACK;
          end else begin
            oe_d    = ~shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
            cnt_d   = cnt_q + BCW'(1);
          end
        end
        RDACK: if (scl_rise) begin
          if (!sda_s) begin
            ptr_d    = ptr_q + MEM_AW'(1);
            mem_rd_d = 1'b1;
            mem_a_d  = ptr_q + MEM_AW'(1);
            state_d  = RDDATA;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: ;
      endcase
    end
  end
  // state and datapath registers; reset releases SDA asynchronously
  always_ff @(posedge clk_in or negedge nrst_in)
    if (!nrst_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      hi_q      <= '0;
      ptr_q     <= '0;
      rd_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_a_q   <= '0;
      mem_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      hi_q      <= hi_d;
      ptr_q     <= ptr_d;
      rd_q      <= rd_d;
      rd_pend_q <= rd_pend_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      mem_a_q   <= mem_a_d;
      mem_d_q   <= mem_d_d;
    end
  assign sda_oe_out = oe_q;
  assign busy_out   = busy_q;
  assign mem_rd_out = mem_rd_q;
  assign mem_wr_out = mem_wr_q;
  assign mem_a_out  = mem_a_q;
  assign mem_d_out  = mem_d_q;
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb_i2c_eeprom_target: bit-level I2C master against a RAM model and an EEPROM reference model
module tb_i2c_eeprom_target;
  localparam int AW = 15;
  localparam int DEPTH = 1 << AW;
  logic clk_in = 1'b0, nrst_in = 1'b0, scl = 1'b1, sda_m = 1'b1;
  logic sda, sda_oe_out, mem_rd_out, mem_wr_out, busy_out;
  logic [AW-1:0] mem_a_out;
  logic [7:0] mem_d_out, mem_d_in;
  int n_chk = 0, n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, oe_cnt = 0;
  logic [22:0] wr_log[$];
  logic [7:0] dmem[DEPTH];
  logic [7:0] ref_mem[DEPTH];
  int ptr = 0;
  assign sda = sda_m & ~sda_oe_out;
  always #5 clk_in = ~clk_in;
  i2c_eeprom_target #(.DEV_ADDR(7'h50), .MEM_AW(AW)) dut (
    .clk_in     (clk_in),
    .nrst_in    (nrst_in),
    .scl_in     (scl),
    .sda_in     (sda),
    .sda_oe_out (sda_oe_out),
    .mem_a_out  (mem_a_out),
    .mem_d_in   (mem_d_in),
    .mem_rd_out (mem_rd_out),
    .mem_d_out  (mem_d_out),
    .mem_wr_out (mem_wr_out),
    .busy_out   (busy_out)
  );
  // synchronous RAM with one clock read latency, plus strobe bookkeeping
  always @(posedge clk_in) begin
    if (mem_rd_out) begin
      mem_d_in <= dmem[mem_a_out];
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_wr_out) begin
      dmem[mem_a_out] <= mem_d_out;
      wr_cnt <= wr_cnt + 1;
      wr_log.push_back({mem_a_out, mem_d_out});
    end
    if (sda_oe_out) oe_cnt <= oe_cnt + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wclk(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; wclk(6);
    scl = 1'b1; wclk(8);
    sda_m = 1'b0; wclk(8);
    scl = 1'b0; wclk(4);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; wclk(6);
    scl = 1'b1; wclk(8);
    sda_m = 1'b1; wclk(10);
  endtask
  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wclk(8);
      scl = 1'b1; wclk(10);
      scl = 1'b0; wclk(2);
    end
  endtask
  task automatic wbyte(input logic [7:0] b, output bit ack);
    send_bits(b);
    sda_m = 1'b1; wclk(8);
    scl = 1'b1; wclk(5);
    ack = ~sda; wclk(5);
    scl = 1'b0; wclk(8);
  endtask
  task automatic rbyte(input bit mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(8);
      scl = 1'b1; wclk(5);
      b[i] = sda; wclk(5);
      scl = 1'b0; wclk(2);
    end
    sda_m = ~mack; wclk(8);
    scl = 1'b1; wclk(10);
    scl = 1'b0; wclk(2);
    sda_m = 1'b1; wclk(6);
  endtask
  task automatic write_txn(input logic [15:0] a, input logic [7:0] dq[$]);
    logic [22:0] exp[$];
    bit ack;
    wr_log.delete();
    i2c_start();
    wbyte(8'hA0, ack); chk("wr_dev_ack", ack, 1);
    wbyte(a[15:8], ack); chk("wr_hi_ack", ack, 1);
    wbyte(a[7:0], ack); chk("wr_lo_ack", ack, 1);
    ptr = int'(a) % DEPTH;
    foreach (dq[k]) begin
      wbyte(dq[k], ack); chk("wr_data_ack", ack, 1);
      exp.push_back({ptr[AW-1:0], dq[k]});
      ref_mem[ptr] = dq[k];
      ptr = (ptr + 1) % DEPTH;
    end
    i2c_stop();
    chk("wr_count", wr_log.size(), exp.size());
    foreach (exp[k]) if (k < wr_log.size()) chk("wr_entry", wr_log[k], exp[k]);
  endtask
  task automatic read_txn(input bit set_addr, input logic [15:0] a, input int n);
    bit ack;
    logic [7:0] b;
    if (set_addr) begin
      i2c_start();
      wbyte(8'hA0, ack); chk("rr_dev_ack", ack, 1);
      wbyte(a[15:8], ack); chk("rr_hi_ack", ack, 1);
      wbyte(a[7:0], ack); chk("rr_lo_ack", ack, 1);
      ptr = int'(a) % DEPTH;
    end
    i2c_start();
    wbyte(8'hA1, ack); chk("rd_dev_ack", ack, 1);
    chk("rd_busy", busy_out, 1);
    for (int k = 0; k < n; k++) begin
      rbyte(k < n - 1, b);
      chk("rd_data", b, ref_mem[ptr]);
      if (k < n - 1) ptr = (ptr + 1) % DEPTH;
    end
    chk("rd_sda_released", sda_oe_out, 0);
    i2c_stop();
    chk("rd_busy_after_stop", busy_out, 0);
  endtask
  typedef struct {
    logic [7:0] ab;
    bit         ack;
  } vec_t;
  vec_t vt[6];
  initial begin
    logic [7:0] dq[$];
    logic [15:0] a;
    int kind, n, rs, ws, os;
    bit ack, got;
    for (int i = 0; i < DEPTH; i++) begin
      dmem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    wclk(3);
    chk("rst_sda_oe", sda_oe_out, 0);
    chk("rst_mem_wr", mem_wr_out, 0);
    chk("rst_mem_rd", mem_rd_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_mem_a", mem_a_out, 0);
    chk("rst_mem_d", mem_d_out, 0);
    nrst_in = 1'b1; wclk(5);
    vt[0] = '{8'hA0, 1'b1};
    vt[1] = '{8'hA2, 1'b0};
    vt[2] = '{8'hA0, 1'b1};
    vt[3] = '{8'hA3, 1'b0};
    vt[4] = '{8'h20, 1'b0};
    vt[5] = '{8'hFE, 1'b0};
    for (int i = 0; i < 6; i++) begin
      rs = rd_cnt; ws = wr_cnt; os = oe_cnt;
      i2c_start();
      wbyte(vt[i].ab, ack);
      chk("tbl_ack", ack, vt[i].ack);
      chk("tbl_busy", busy_out, vt[i].ack);
      i2c_stop();
      chk("tbl_busy_stop", busy_out, 0);
      if (!vt[i].ack) begin
        chk("tbl_nack_oe", oe_cnt - os, 0);
        chk("tbl_nack_strobes", (rd_cnt - rs) + (wr_cnt - ws), 0);
      end
    end
    dq = {8'hA5, 8'h5A};
    write_txn(16'h0123, dq);
    read_txn(1'b1, 16'h0123, 2);
    chk("rd_a5", ref_mem[16'h0123], 8'hA5);
    dq = {8'hC3, 8'h3D};
    write_txn(16'hFFFF, dq);
    chk("wrap_write_addr", wr_log.size() > 1 ? wr_log[1][22:8] : 15'h7FFF, 15'h0000);
    read_txn(1'b1, 16'h7FFF, 2);
    ws = wr_cnt;
    i2c_start();
    wbyte(8'hA0, ack); chk("hi_only_dev_ack", ack, 1);
    wbyte(8'h12, ack); chk("hi_only_hi_ack", ack, 1);
    i2c_stop();
    read_txn(1'b0, 16'h0000, 1);
    chk("hi_only_no_write", wr_cnt - ws, 0);
    i2c_start();
    send_bits(8'hA0);
    sda_m = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      wclk(1);
      got = sda_oe_out;
    end
    chk("ack_before_reset", got, 1);
    nrst_in = 1'b0;
    #1;
    chk("reset_releases_sda", sda_oe_out, 0);
    chk("reset_busy", busy_out, 0);
    scl = 1'b1; wclk(4);
    nrst_in = 1'b1; wclk(4);
    ptr = 0;
    read_txn(1'b0, 16'h0000, 1);
    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 2);
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'h7FFD;
      n = $urandom_range(1, 4);
      dq.delete();
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      if (kind == 0) write_txn(a, dq);
      else read_txn(kind == 1, a, n);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
